// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the single-issue RISC-V datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath controls. mem_ready stretches FETCH and MEM. The block counts
// retired instructions and halts on an illegal opcode or a memory timeout.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,  // max wait cycles for mem_ready; 0 disables
   parameter int CNT_W       = 32   // width of instr_count
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             enable,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [1:0]       alu_op,
   output logic             alu_src,
   output logic             mem_2_reg,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             branch,
   output logic             jump,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count,
   output logic             illegal,
   output logic             bus_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   // wait_cnt only has to reach MEM_TIMEOUT-1 before the timeout fires
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t            state, state_nxt;
   logic [6:0]        op_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting;
   logic              timeout;
   logic              retire;
   logic              set_illegal;

   // State register; an undefined encoding recovers through the next-state default
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic and all datapath controls, decoded from state/op_q/zero/mem_ready
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_nxt   = state;
      alu_op      = 2'b00;
      alu_src     = 1'b0;
      mem_2_reg   = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      retire      = 1'b0;
      set_illegal = 1'b0;
      waiting     = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
      timeout     = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == WAIT_LAST);

      case (state)
         S_IDLE: begin
            if (enable) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = S_DECODE;
            end else if (timeout) begin
               state_nxt = S_HALT;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_R, OP_I, OP_BEQ, OP_JAL, OP_LOAD, OP_STORE: state_nxt = S_EXEC;
               default: begin
                  set_illegal = 1'b1;
                  state_nxt   = S_HALT;
               end
            endcase
         end
         S_EXEC: begin
            case (op_q)
               OP_R: begin
                  alu_op    = 2'b10;
                  state_nxt = S_WB;
               end
               OP_I: begin
                  alu_src   = 1'b1;
                  state_nxt = S_WB;
               end
               OP_BEQ: begin
                  alu_op    = 2'b01;
                  branch    = 1'b1;
                  pc_src    = 1'b1;
                  pc_write  = zero;
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end
               OP_JAL: begin
                  jump      = 1'b1;
                  reg_write = 1'b1;
                  pc_src    = 1'b1;
                  pc_write  = 1'b1;
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src   = 1'b1;
                  state_nxt = S_MEM;
               end
               default: state_nxt = S_IDLE;
            endcase
         end
         S_MEM: begin
            alu_src = 1'b1;
            if (op_q == OP_LOAD) mem_read  = 1'b1;
            else                 mem_write = 1'b1;
            if (mem_ready) begin
               if (op_q == OP_LOAD) begin
                  state_nxt = S_WB;
               end else begin
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end
            end else if (timeout) begin
               state_nxt = S_HALT;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
            case (op_q)
               OP_LOAD: begin
                  mem_2_reg = 1'b1;
                  alu_src   = 1'b1;
               end
               OP_R:    alu_op  = 2'b10;
               OP_I:    alu_src = 1'b1;
               default: ;
            endcase
         end
         S_HALT: ;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign instr_done = retire;

   // Opcode latch, wait counter, retire counter and sticky error flags
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         op_q        <= '0;
         wait_cnt    <= '0;
         instr_count <= '0;
         illegal     <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         if (state == S_DECODE) op_q <= opcode;
         // Any cycle that is not a stalled memory wait leaves the counter at 0,
         // so it is already clear whenever FETCH or MEM is entered.
         if (waiting && !timeout) wait_cnt <= wait_cnt + 1'b1;
         else                     wait_cnt <= '0;
         if (retire)      instr_count <= instr_count + CNT_W'(1);
         if (set_illegal) illegal     <= 1'b1;
         if (timeout)     bus_err     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=8, CNT_W=4).
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       enable;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic [1:0] alu_op;
   logic       alu_src, mem_2_reg, reg_write, mem_read, mem_write;
   logic       ir_write, pc_write, pc_src, branch, jump, instr_done;
   logic [3:0] instr_count;
   logic       illegal, bus_err;
   logic [12:0] ctrl;

   int n_checks = 0;
   int n_err    = 0;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   // Field order: alu_op(2) alu_src mem_2_reg reg_write mem_read mem_write
   //              ir_write pc_write pc_src branch jump instr_done
   localparam logic [12:0] C_NONE     = 13'b00_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] C_F_WAIT   = 13'b00_0_0_0_1_0_0_0_0_0_0_0;
   localparam logic [12:0] C_F_RDY    = 13'b00_0_0_0_1_0_1_1_0_0_0_0;
   localparam logic [12:0] C_EX_IMM   = 13'b00_1_0_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] C_WB_I     = 13'b00_1_0_1_0_0_0_0_0_0_0_1;
   localparam logic [12:0] C_EX_R     = 13'b10_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] C_WB_R     = 13'b10_0_0_1_0_0_0_0_0_0_0_1;
   localparam logic [12:0] C_MEM_LD   = 13'b00_1_0_0_1_0_0_0_0_0_0_0;
   localparam logic [12:0] C_WB_LD    = 13'b00_1_1_1_0_0_0_0_0_0_0_1;
   localparam logic [12:0] C_MEM_ST   = 13'b00_1_0_0_0_1_0_0_0_0_0_0;
   localparam logic [12:0] C_MEM_STD  = 13'b00_1_0_0_0_1_0_0_0_0_0_1;
   localparam logic [12:0] C_BEQ_T    = 13'b01_0_0_0_0_0_0_1_1_1_0_1;
   localparam logic [12:0] C_BEQ_N    = 13'b01_0_0_0_0_0_0_0_1_1_0_1;
   localparam logic [12:0] C_JAL      = 13'b00_0_0_1_0_0_0_1_1_0_1_1;

   multicycle_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
      .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode),
      .zero(zero), .mem_ready(mem_ready), .alu_op(alu_op), .alu_src(alu_src),
      .mem_2_reg(mem_2_reg), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .branch(branch), .jump(jump), .instr_done(instr_done),
      .instr_count(instr_count), .illegal(illegal), .bus_err(bus_err)
   );

   assign ctrl = {alu_op, alu_src, mem_2_reg, reg_write, mem_read, mem_write,
                  ir_write, pc_write, pc_src, branch, jump, instr_done};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Let combinational outputs settle, compare them, then advance one clock
   task automatic cyc(input string tag, input logic [12:0] exp);
      #2;
      check(tag, 32'(ctrl), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   initial begin
      arst_n = 1'b0; enable = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
      #3;
      check("rst_ctrl", 32'(ctrl), 32'(C_NONE));
      check("rst_count", 32'(instr_count), 32'd0);
      check("rst_flags", {30'd0, illegal, bus_err}, 32'd0);
      @(posedge clk); #1;
      arst_n = 1'b1;

      // IDLE holds without enable, then leaves on enable
      cyc("idle_hold", C_NONE);
      enable = 1'b1; mem_ready = 1'b1; opcode = OP_I;
      cyc("idle_go", C_NONE);
      enable = 1'b0;

      // addi, zero-wait memory: 4 cycles
      cyc("addi_fetch", C_F_RDY);
      cyc("addi_decode", C_NONE);
      cyc("addi_exec", C_EX_IMM);
      cyc("addi_wb", C_WB_I);
      check("addi_count", 32'(instr_count), 32'd1);

      // lw with three wait cycles in MEM: 8 cycles
      opcode = OP_LOAD;
      cyc("lw_fetch", C_F_RDY);
      cyc("lw_decode", C_NONE);
      cyc("lw_exec", C_EX_IMM);
      mem_ready = 1'b0;
      cyc("lw_mem_w0", C_MEM_LD);
      cyc("lw_mem_w1", C_MEM_LD);
      cyc("lw_mem_w2", C_MEM_LD);
      mem_ready = 1'b1;
      cyc("lw_mem_rdy", C_MEM_LD);
      cyc("lw_wb", C_WB_LD);
      check("lw_count", 32'(instr_count), 32'd2);

      // R-type
      opcode = OP_R;
      cyc("r_fetch", C_F_RDY);
      cyc("r_decode", C_NONE);
      cyc("r_exec", C_EX_R);
      cyc("r_wb", C_WB_R);
      check("r_count", 32'(instr_count), 32'd3);

      // store with one wait cycle, retires from MEM
      opcode = OP_STORE;
      cyc("sw_fetch", C_F_RDY);
      cyc("sw_decode", C_NONE);
      cyc("sw_exec", C_EX_IMM);
      mem_ready = 1'b0;
      cyc("sw_mem_w0", C_MEM_ST);
      mem_ready = 1'b1;
      cyc("sw_mem_rdy", C_MEM_STD);
      check("sw_count", 32'(instr_count), 32'd4);

      // beq taken then not taken
      opcode = OP_BEQ; zero = 1'b1;
      cyc("beq_t_fetch", C_F_RDY);
      cyc("beq_t_decode", C_NONE);
      cyc("beq_t_exec", C_BEQ_T);
      check("beq_t_count", 32'(instr_count), 32'd5);
      zero = 1'b0;
      cyc("beq_n_fetch", C_F_RDY);
      cyc("beq_n_decode", C_NONE);
      cyc("beq_n_exec", C_BEQ_N);
      check("beq_n_count", 32'(instr_count), 32'd6);

      // jal
      opcode = OP_JAL;
      cyc("jal_fetch", C_F_RDY);
      cyc("jal_decode", C_NONE);
      cyc("jal_exec", C_JAL);
      check("jal_count", 32'(instr_count), 32'd7);

      // mem_ready on the last allowed wait cycle wins over the timeout
      mem_ready = 1'b0;
      for (int i = 0; i < 7; i++) cyc("edge_fetch_wait", C_F_WAIT);
      mem_ready = 1'b1;
      cyc("edge_fetch_rdy", C_F_RDY);
      cyc("edge_decode", C_NONE);
      cyc("edge_exec", C_JAL);
      check("edge_no_buserr", {31'd0, bus_err}, 32'd0);
      check("edge_count", 32'(instr_count), 32'd8);

      // Reset while a store is waiting in MEM drops mem_write at once
      opcode = OP_STORE;
      cyc("rst_sw_fetch", C_F_RDY);
      cyc("rst_sw_decode", C_NONE);
      cyc("rst_sw_exec", C_EX_IMM);
      mem_ready = 1'b0;
      #2;
      check("rst_sw_mem", 32'(ctrl), 32'(C_MEM_ST));
      arst_n = 1'b0;
      #1;
      check("rst_mid_ctrl", 32'(ctrl), 32'(C_NONE));
      check("rst_mid_count", 32'(instr_count), 32'd0);
      @(posedge clk); #1;
      arst_n = 1'b1;

      // 16 jal instructions wrap the 4-bit counter back to 0
      enable = 1'b1; mem_ready = 1'b1; opcode = OP_JAL;
      cyc("wrap_idle", C_NONE);
      enable = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cyc("wrap_fetch", C_F_RDY);
         cyc("wrap_decode", C_NONE);
         cyc("wrap_exec", C_JAL);
      end
      check("wrap_count15", 32'(instr_count), 32'd15);
      cyc("wrap_fetch_last", C_F_RDY);
      cyc("wrap_decode_last", C_NONE);
      cyc("wrap_exec_last", C_JAL);
      check("wrap_count0", 32'(instr_count), 32'd0);

      // Illegal opcode halts after DECODE; HALT ignores enable and mem_ready
      opcode = 7'h7F;
      cyc("ill_fetch", C_F_RDY);
      cyc("ill_decode", C_NONE);
      check("ill_flags", {30'd0, illegal, bus_err}, 32'd2);
      enable = 1'b1;
      for (int i = 0; i < 20; i++) cyc("halt_quiet", C_NONE);
      check("halt_flags", {30'd0, illegal, bus_err}, 32'd2);
      check("halt_count", 32'(instr_count), 32'd0);

      // Reset clears the sticky flag, then a fetch that never completes times out
      arst_n = 1'b0; enable = 1'b0;
      #1;
      check("rst_ill_clear", {31'd0, illegal}, 32'd0);
      @(posedge clk); #1;
      arst_n = 1'b1;
      enable = 1'b1; mem_ready = 1'b0;
      cyc("to_idle", C_NONE);
      for (int i = 0; i < 8; i++) cyc("to_fetch_wait", C_F_WAIT);
      #2;
      check("to_halt_ctrl", 32'(ctrl), 32'(C_NONE));
      check("to_flags", {30'd0, illegal, bus_err}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
